// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, constants and types for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned REG_ZERO   = 0;

  // Which source wins the next two-way tie
  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the last winner loses the next tie.
module rr_arb2
  import regfile_wb_arbiter_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic reqA,
  input  logic reqB,
  output logic gntA,
  output logic gntB
);

  prio_e prio;
  prio_e prio_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      prio <= PRIO_A;
    end else begin
      prio <= prio_next;
    end
  end

  always_comb begin
    gntA      = 1'b0;
    gntB      = 1'b0;
    prio_next = prio;
    if (reqA && (!reqB || prio == PRIO_A)) begin
      gntA      = 1'b1;
      prio_next = PRIO_B;
    end else if (reqB) begin
      gntB      = 1'b1;
      prio_next = PRIO_A;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU (A) and load (B) writeback,
// and tracks pending writes so decode can stall on RAW hazards.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  AValid,
  input  logic [ADDR_W-1:0]     AReg,
  input  logic [DATA_W-1:0]     AData,
  output logic                  AReady,
  input  logic                  BValid,
  input  logic [ADDR_W-1:0]     BReg,
  input  logic [DATA_W-1:0]     BData,
  output logic                  BReady,
  input  logic                  IssueValid,
  input  logic [ADDR_W-1:0]     IssueReg,
  input  logic [ADDR_W-1:0]     Readreg1,
  input  logic [ADDR_W-1:0]     Readreg2,
  output logic                  Stall,
  output logic [2**ADDR_W-1:0]  Busy,
  output logic                  RegWrite,
  output logic [ADDR_W-1:0]     Writereg,
  output logic [DATA_W-1:0]     Writedata
);

  localparam int unsigned NREG = 2**ADDR_W;

  logic              gnt_a;
  logic              gnt_b;
  logic              gnt_any;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;
  logic [NREG-1:0]   busy_next;

  rr_arb2 u_arb (
    .clock (clock),
    .reset (reset),
    .reqA  (AValid),
    .reqB  (BValid),
    .gntA  (gnt_a),
    .gntB  (gnt_b)
  );

  assign gnt_any = gnt_a | gnt_b;
  assign AReady  = gnt_a & ~reset;
  assign BReady  = gnt_b & ~reset;
  assign Stall   = Busy[Readreg1] | Busy[Readreg2];

  always_comb begin
    sel_reg  = AReg;
    sel_data = AData;
    if (gnt_b) begin
      sel_reg  = BReg;
      sel_data = BData;
    end
  end

  // Commit clears, issue sets afterwards so a same-edge set wins
  always_comb begin
    busy_next = Busy;
    if (RegWrite) begin
      busy_next[Writereg] = 1'b0;
    end
    if (IssueValid && IssueReg != ADDR_W'(REG_ZERO)) begin
      busy_next[IssueReg] = 1'b1;
    end
    busy_next[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      Busy      <= '0;
      RegWrite  <= 1'b0;
      Writereg  <= '0;
      Writedata <= '0;
    end else begin
      Busy     <= busy_next;
      RegWrite <= gnt_any && (sel_reg != ADDR_W'(REG_ZERO));
      if (gnt_any) begin
        Writereg  <= sel_reg;
        Writedata <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed plus random checks of the writeback arbiter against a cycle model.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          AValid, BValid, IssueValid;
  logic [AW-1:0] AReg, BReg, IssueReg, Readreg1, Readreg2;
  logic [DW-1:0] AData, BData;
  logic          AReady, BReady, Stall, RegWrite;
  logic [NR-1:0] Busy;
  logic [AW-1:0] Writereg;
  logic [DW-1:0] Writedata;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic          rw;
    logic [AW-1:0] wr;
    logic [DW-1:0] wd;
    logic [NR-1:0] busy;
    logic          prio;
  } exp_t;

  exp_t q[$];
  exp_t m;

  always #5 clock = ~clock;

  regfile_wb_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .AValid     (AValid),
    .AReg       (AReg),
    .AData      (AData),
    .AReady     (AReady),
    .BValid     (BValid),
    .BReg       (BReg),
    .BData      (BData),
    .BReady     (BReady),
    .IssueValid (IssueValid),
    .IssueReg   (IssueReg),
    .Readreg1   (Readreg1),
    .Readreg2   (Readreg2),
    .Stall      (Stall),
    .Busy       (Busy),
    .RegWrite   (RegWrite),
    .Writereg   (Writereg),
    .Writedata  (Writedata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check same-cycle outputs, queue the expected registered state, compare after the edge
  task automatic step(input string tag);
    logic ga, gb;
    exp_t e, got;
    #1;
    ga = !reset && AValid && (!BValid || m.prio == 1'b0);
    gb = !reset && BValid && !ga;
    chk({tag, ".a_ready"}, 64'(AReady), 64'(ga));
    chk({tag, ".b_ready"}, 64'(BReady), 64'(gb));
    if (!reset) chk({tag, ".stall"}, 64'(Stall), 64'(m.busy[Readreg1] | m.busy[Readreg2]));
    if (reset) begin
      e = '0;
    end else begin
      e = m;
      e.rw = (ga && AReg != 0) || (gb && BReg != 0);
      if (ga) begin e.wr = AReg; e.wd = AData; e.prio = 1'b1; end
      if (gb) begin e.wr = BReg; e.wd = BData; e.prio = 1'b0; end
      if (m.rw) e.busy[m.wr] = 1'b0;
      if (IssueValid && IssueReg != 0) e.busy[IssueReg] = 1'b1;
    end
    q.push_back(e);
    @(posedge clock);
    #1;
    got = q.pop_front();
    chk({tag, ".reg_write"}, 64'(RegWrite), 64'(got.rw));
    chk({tag, ".write_reg"}, 64'(Writereg), 64'(got.wr));
    chk({tag, ".write_data"}, 64'(Writedata), 64'(got.wd));
    chk({tag, ".busy"}, 64'(Busy), 64'(got.busy));
    m = got;
  endtask

  task automatic idle();
    AValid = 0; BValid = 0; IssueValid = 0;
  endtask

  initial begin
    m = '0;
    reset = 1; idle();
    AReg = 0; BReg = 0; AData = 0; BData = 0; IssueReg = 0; Readreg1 = 0; Readreg2 = 0;
    step("reset0");
    step("reset1");
    reset = 0;

    // single A write
    AValid = 1; AReg = 5; AData = 32'hDEAD_BEEF;
    step("t1_grant");
    chk("t1_wr", 64'(Writereg), 64'd5);
    chk("t1_wd", 64'(Writedata), 64'hDEAD_BEEF);
    chk("t1_rw", 64'(RegWrite), 64'd1);
    idle();
    step("t1_idle");

    // both valid after reset: A then B
    reset = 1; step("t2_reset"); reset = 0;
    AValid = 1; AReg = 3; AData = 32'h3333;
    BValid = 1; BReg = 4; BData = 32'h4444;
    step("t2_c0");
    chk("t2_c0_wr", 64'(Writereg), 64'd3);
    step("t2_c1");
    chk("t2_c1_wr", 64'(Writereg), 64'd4);
    chk("t2_c1_rw", 64'(RegWrite), 64'd1);
    idle();
    step("t2_idle");

    // RAW stall until write data is valid
    IssueValid = 1; IssueReg = 7;
    step("t3_issue");
    IssueValid = 0; Readreg1 = 7;
    step("t3_wait");
    BValid = 1; BReg = 7; BData = 32'h7777;
    #1 chk("t3_stall_n", 64'(Stall), 64'd1);
    step("t3_grant");
    BValid = 0;
    #1 chk("t3_stall_n1", 64'(Stall), 64'd1);
    step("t3_commit");
    #1 chk("t3_stall_n2", 64'(Stall), 64'd0);
    Readreg1 = 0;

    // register 0 writes and issues are ignored
    AValid = 1; AReg = 0; AData = 32'hFFFF_FFFF;
    IssueValid = 1; IssueReg = 0;
    step("t4_zero");
    chk("t4_rw", 64'(RegWrite), 64'd0);
    chk("t4_busy", 64'(Busy), 64'd0);
    idle();

    // same-edge set and clear: set wins
    IssueValid = 1; IssueReg = 9;
    step("t5_issue");
    IssueValid = 0; BValid = 1; BReg = 9; BData = 32'h9999;
    step("t5_grant");
    BValid = 0; IssueValid = 1; IssueReg = 9;
    step("t5_commit_issue");
    chk("t5_busy9", 64'(Busy[9]), 64'd1);
    idle();

    // reset with a staged write and pending scoreboard bits
    reset = 1; step("t6_clr"); reset = 0;
    for (int r = 4; r <= 6; r++) begin
      IssueValid = 1; IssueReg = AW'(r);
      step("t6_issue");
    end
    IssueReg = 7; AValid = 1; AReg = 12; AData = 32'hC0C0;
    step("t6_stage");
    chk("t6_busy_f0", 64'(Busy), 64'h0000_00F0);
    chk("t6_staged", 64'(RegWrite), 64'd1);
    idle(); AValid = 1; AReg = 13;
    reset = 1;
    step("t6_reset");
    chk("t6_rw0", 64'(RegWrite), 64'd0);
    chk("t6_busy0", 64'(Busy), 64'd0);
    reset = 0;
    AValid = 1; AReg = 1; AData = 32'h1; BValid = 1; BReg = 2; BData = 32'h2;
    #1 chk("t6_prio_a", 64'(AReady), 64'd1);
    step("t6_after");
    idle();

    // random traffic against the model
    for (int i = 0; i < 60; i++) begin
      AValid = 1'($urandom); BValid = 1'($urandom); IssueValid = 1'($urandom);
      AReg = AW'($urandom); BReg = AW'($urandom); IssueReg = AW'($urandom);
      AData = $urandom; BData = $urandom;
      Readreg1 = AW'($urandom); Readreg2 = AW'($urandom);
      reset = ($urandom_range(0, 19) == 0);
      step("rnd");
    end
    reset = 0; idle();
    step("end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
